multicycle_controller: RTL and testbench

- Moore FSM that sequences a multicycle MIPS datapath: one shared memory for instructions and data, one ALU, instruction register, PC.
- Decodes the same opcode subset as the single-cycle decoder: lw, sw, beq, j, addi, R-type.
- Drives datapath mux selects, write enables and ALU op class per cycle.
- Stalls on a memory-ready handshake.
- Sits between the instruction register opcode field and the datapath; the ALU decoder consumes aluop.

---
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore FSM sequencing a multicycle MIPS datapath (shared
//             instruction/data memory, single ALU, IR, PC). Supports lw, sw,
//             beq, j, addi and R-type; stalls on the memory-ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       iord,
    output logic       wemem,
    output logic       irwrite,
    output logic       werf,
    output logic       rfwasrc,
    output logic       memToRf,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;

    // Memory handshake can be tied off for zero-wait-state memories
    generate
        if (USE_MEM_READY) begin : g_mem_ready
            assign mem_rdy = mem_ready;
        end else begin : g_no_mem_ready
            assign mem_rdy = 1'b1;
        end
    endgenerate

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Next-state and per-state datapath controls (Moore, plus mem_ready in FETCH)
    always_comb begin
        state_d = S_FETCH;
        pcwrite = 1'b0;
        branch  = 1'b0;
        iord    = 1'b0;
        wemem   = 1'b0;
        irwrite = 1'b0;
        werf    = 1'b0;
        rfwasrc = 1'b0;
        memToRf = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        aluop   = 2'b00;
        pcsrc   = 2'b00;
        illegal = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;          // PC + 4
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
                state_d = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;          // precompute branch target
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                werf    = 1'b1;
                memToRf = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                // Write enable held through every stall cycle
                iord    = 1'b1;
                wemem   = 1'b1;
                state_d = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                werf    = 1'b1;
                rfwasrc = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                werf    = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unreachable codes recover to FETCH with all controls idle
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Directed scoreboard bench for multicycle_controller. The driver
//             pushes the hand-computed state/control vector for each cycle;
//             a monitor pops and compares when the DUT outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    // Control vector packing:
    // {pcwrite,branch,iord,wemem,irwrite,werf,rfwasrc,memToRf,
    //  alusrca,alusrcb[1:0],aluop[1:0],pcsrc[1:0],illegal}
    localparam logic [15:0] C_FETCH    = 16'h8820;
    localparam logic [15:0] C_FETCH_ST = 16'h0020;
    localparam logic [15:0] C_DECODE   = 16'h0060;
    localparam logic [15:0] C_DEC_ILL  = 16'h0061;
    localparam logic [15:0] C_MEMADR   = 16'h00C0;
    localparam logic [15:0] C_MEMRD    = 16'h2000;
    localparam logic [15:0] C_MEMWB    = 16'h0500;
    localparam logic [15:0] C_MEMWR    = 16'h3000;
    localparam logic [15:0] C_EXECUTE  = 16'h0090;
    localparam logic [15:0] C_ALUWB    = 16'h0600;
    localparam logic [15:0] C_BRANCH   = 16'h408A;
    localparam logic [15:0] C_ADDIEX   = 16'h00C0;
    localparam logic [15:0] C_ADDIWB   = 16'h0400;
    localparam logic [15:0] C_JUMP     = 16'h8004;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite, branch, iord, wemem, irwrite, werf, rfwasrc, memToRf;
    logic       alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    logic        probe;
    logic [19:0] exp_q[$];
    int          errors;
    int          checks;

    multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .mem_ready(mem_ready),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .iord     (iord),
        .wemem    (wemem),
        .irwrite  (irwrite),
        .werf     (werf),
        .rfwasrc  (rfwasrc),
        .memToRf  (memToRf),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .pcsrc    (pcsrc),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample mid-cycle (or on an explicit probe) and score
    always @(negedge clk or posedge probe) begin
        logic [19:0] e;
        logic [15:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pcwrite, branch, iord, wemem, irwrite, werf, rfwasrc, memToRf,
                   alusrca, alusrcb, aluop, pcsrc, illegal};
            checks = checks + 1;
            if (state !== e[19:16]) begin
                errors = errors + 1;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, e[19:16]);
            end
            checks = checks + 1;
            if (act !== e[15:0]) begin
                errors = errors + 1;
                $display("FAIL controls @%0t (state %0d): got %h expected %h",
                         $time, state, act, e[15:0]);
            end
        end
    end

    // One clock cycle of stimulus with its expected state/controls
    task automatic cyc(input logic [5:0] op, input logic mr, input logic rs,
                       input logic [3:0] st, input logic [15:0] ov);
        opcode    = op;
        mem_ready = mr;
        reset     = rs;
        exp_q.push_back({st, ov});
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        probe     = 1'b0;
        reset     = 1'b1;
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: FETCH controls
        cyc(6'b100011, 1'b1, 1'b1, 4'd0, C_FETCH);

        // lw, 5 cycles; opcode disturbed after MEMADR has no effect
        cyc(6'b100011, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b100011, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc(6'b100011, 1'b1, 1'b0, 4'd2, C_MEMADR);
        cyc(6'b000100, 1'b1, 1'b0, 4'd3, C_MEMRD);
        cyc(6'b111111, 1'b1, 1'b0, 4'd4, C_MEMWB);

        // sw with two stall cycles in MEMWR
        cyc(6'b101011, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b101011, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc(6'b101011, 1'b1, 1'b0, 4'd2, C_MEMADR);
        cyc(6'b101011, 1'b0, 1'b0, 4'd5, C_MEMWR);
        cyc(6'b101011, 1'b0, 1'b0, 4'd5, C_MEMWR);
        cyc(6'b101011, 1'b1, 1'b0, 4'd5, C_MEMWR);

        // R-type
        cyc(6'b000000, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b000000, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc(6'b000000, 1'b1, 1'b0, 4'd6, C_EXECUTE);
        cyc(6'b000000, 1'b1, 1'b0, 4'd7, C_ALUWB);

        // beq
        cyc(6'b000100, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b000100, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc(6'b000100, 1'b1, 1'b0, 4'd8, C_BRANCH);

        // j
        cyc(6'b000010, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b000010, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc(6'b000010, 1'b1, 1'b0, 4'd11, C_JUMP);

        // Illegal opcode: one-cycle flag, back to FETCH
        cyc(6'b111111, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b111111, 1'b1, 1'b0, 4'd1, C_DEC_ILL);

        // FETCH stalled three cycles, then addi
        cyc(6'b001000, 1'b0, 1'b0, 4'd0, C_FETCH_ST);
        cyc(6'b001000, 1'b0, 1'b0, 4'd0, C_FETCH_ST);
        cyc(6'b001000, 1'b0, 1'b0, 4'd0, C_FETCH_ST);
        cyc(6'b001000, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b001000, 1'b1, 1'b0, 4'd1, C_DECODE);

        // ADDIEX, then asynchronous reset in the second half of the cycle
        opcode    = 6'b001000;
        mem_ready = 1'b1;
        exp_q.push_back({4'd9, C_ADDIEX});
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back({4'd0, C_FETCH});
        probe = 1'b1;
        #1;
        probe = 1'b0;
        @(posedge clk);
        #1;
        cyc(6'b001000, 1'b1, 1'b1, 4'd0, C_FETCH);

        // Fresh addi after reset: 4 cycles, ADDIWB writes rt with ALU out
        cyc(6'b001000, 1'b1, 1'b0, 4'd0, C_FETCH);
        cyc(6'b001000, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc(6'b001000, 1'b1, 1'b0, 4'd9, C_ADDIEX);
        cyc(6'b001000, 1'b1, 1'b0, 4'd10, C_ADDIWB);
        cyc(6'b000000, 1'b0, 1'b0, 4'd0, C_FETCH_ST);

        @(posedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        errors = errors + 1;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
